// File: rtl/m_pkg.sv
// Shared types for the matcher core and its host-side slot scheduler.
// Holds the slot-table entry layout, scheduler opcodes, FSM states and a
// popcount helper used to derive the slot occupancy count.
package m_pkg;

    localparam int unsigned SLOTS_N = 4;
    localparam int unsigned OFF_W   = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned BUF_W   = 2;

    typedef logic [OFF_W-1:0]  packet_word_off_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [BUF_W-1:0]  buffer_t;
    typedef logic [1:0]        slot_t;

    typedef enum logic {
        OP_INSTALL = 1'b0,
        OP_REMOVE  = 1'b1
    } sched_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic             valid;
        packet_word_off_t off;
        data_t            match;
        buffer_t          buffer;
    } sym_match_t;

    // Number of valid entries in a slot table (0..SLOTS_N).
    function automatic logic [2:0] popcount_valid(input sym_match_t [SLOTS_N-1:0] tab);
        logic [2:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(SLOTS_N); i++) begin
            cnt = cnt + 3'(tab[i].valid);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/m_match_sched_if.sv
// Requester <-> scheduler bundle.
//   req_vld/req_rdy      : per-requester valid/ready handshake (rdy is one-hot)
//   req_op/slot/off/...  : per-requester command fields
//   rsp_vld_r            : one-hot, one-cycle response strobe to the granted requester
//   rsp_ok_r/rsp_slot_r  : response payload, shared by all requesters
// master = host requesters, slave = scheduler.
interface m_match_sched_if #(
    parameter int unsigned N_REQ = 4
);
    import m_pkg::*;

    logic [N_REQ-1:0]                   req_vld;
    logic [N_REQ-1:0]                   req_rdy;
    sched_op_t [N_REQ-1:0]              req_op;
    slot_t [N_REQ-1:0]                  req_slot;
    packet_word_off_t [N_REQ-1:0]       req_off;
    data_t [N_REQ-1:0]                  req_match;
    buffer_t [N_REQ-1:0]                req_buffer;
    logic [N_REQ-1:0]                   rsp_vld_r;
    logic                               rsp_ok_r;
    slot_t                              rsp_slot_r;

    modport master (
        output req_vld, req_op, req_slot, req_off, req_match, req_buffer,
        input  req_rdy, rsp_vld_r, rsp_ok_r, rsp_slot_r
    );

    modport slave (
        input  req_vld, req_op, req_slot, req_off, req_match, req_buffer,
        output req_rdy, rsp_vld_r, rsp_ok_r, rsp_slot_r
    );

endinterface

// File: rtl/m_rr_arb.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   ptr     : highest-priority index this round
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : index of the granted requester (0 when no request)
module m_rr_arb #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] gnt_idx
);

    int   idx;
    logic found;

    // Scan from ptr upward with wrap; first requester seen wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < int'(N); i++) begin
            idx = (int'(ptr) + i) % int'(N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IdxW'(idx);
            end
        end
    end

endmodule

// File: rtl/m_match_sched.sv
// Host-side scheduler for the matcher's symbol-match slot table.
//   clk_host        : host clock
//   rst_host        : asynchronous active-low reset
//   bus             : requester handshake/command/response bundle (slave side)
//   symbol_match_r  : registered slot table, drives the matcher's symbol_match_w
//   occ_r           : number of valid slots
//   busy_r          : high whenever a command is in flight (state != idle)
// One command per 3 cycles: accept (IDLE), execute (EXEC), respond (RESP).
module m_match_sched
    import m_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic                      clk_host,
    input  logic                      rst_host,
    m_match_sched_if.slave            bus,
    output sym_match_t [SLOTS_N-1:0]  symbol_match_r,
    output logic [2:0]                occ_r,
    output logic                      busy_r
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    sched_state_t              state_q, state_d;
    logic [IdxW-1:0]           ptr_q, ptr_d;
    logic [IdxW-1:0]           gnt_q, gnt_d;
    sched_op_t                 op_q, op_d;
    slot_t                     slot_q, slot_d;
    packet_word_off_t          off_q, off_d;
    data_t                     match_q, match_d;
    buffer_t                   buf_q, buf_d;
    sym_match_t [SLOTS_N-1:0]  tab_q, tab_d;
    logic [2:0]                occ_q, occ_d;
    logic                      busy_q, busy_d;
    logic [N_REQ-1:0]          rsp_vld_q, rsp_vld_d;
    logic                      rsp_ok_q, rsp_ok_d;
    slot_t                     rsp_slot_q, rsp_slot_d;

    logic [N_REQ-1:0]          arb_gnt;
    logic [IdxW-1:0]           arb_idx;

    logic                      hit_found, free_found;
    slot_t                     hit_idx, free_idx;

    m_rr_arb #(
        .N    (N_REQ),
        .IdxW (IdxW)
    ) u_arb (
        .req     (bus.req_vld),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Rdy is only offered while idle so a command is never accepted mid-flight.
    assign bus.req_rdy    = (state_q == StIdle) ? arb_gnt : '0;
    assign bus.rsp_vld_r  = rsp_vld_q;
    assign bus.rsp_ok_r   = rsp_ok_q;
    assign bus.rsp_slot_r = rsp_slot_q;
    assign symbol_match_r = tab_q;
    assign occ_r          = occ_q;
    assign busy_r         = busy_q;

    // Lowest-index hit and lowest-index free slot (descending scan keeps the lowest).
    always_comb begin
        hit_found  = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = int'(SLOTS_N) - 1; i >= 0; i--) begin
            if (tab_q[i].valid && tab_q[i].off == off_q && tab_q[i].match == match_q) begin
                hit_found = 1'b1;
                hit_idx   = slot_t'(i);
            end
            if (!tab_q[i].valid) begin
                free_found = 1'b1;
                free_idx   = slot_t'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        op_d       = op_q;
        slot_d     = slot_q;
        off_d      = off_q;
        match_d    = match_q;
        buf_d      = buf_q;
        tab_d      = tab_q;
        rsp_vld_d  = '0;
        rsp_ok_d   = rsp_ok_q;
        rsp_slot_d = rsp_slot_q;

        unique case (state_q)
            StIdle: begin
                if (|bus.req_vld) begin
                    gnt_d   = arb_idx;
                    op_d    = bus.req_op[arb_idx];
                    slot_d  = bus.req_slot[arb_idx];
                    off_d   = bus.req_off[arb_idx];
                    match_d = bus.req_match[arb_idx];
                    buf_d   = bus.req_buffer[arb_idx];
                    ptr_d   = IdxW'((int'(arb_idx) + 1) % int'(N_REQ));
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d          = StResp;
                rsp_vld_d[gnt_q] = 1'b1;
                rsp_ok_d         = 1'b0;
                rsp_slot_d       = '0;
                if (op_q == OP_INSTALL) begin
                    if (hit_found) begin
                        tab_d[hit_idx].buffer = buf_q;
                        rsp_ok_d              = 1'b1;
                        rsp_slot_d            = hit_idx;
                    end else if (free_found) begin
                        tab_d[free_idx] = '{valid: 1'b1, off: off_q, match: match_q,
                                            buffer: buf_q};
                        rsp_ok_d        = 1'b1;
                        rsp_slot_d      = free_idx;
                    end
                end else if (tab_q[slot_q].valid) begin
                    tab_d[slot_q] = '0;
                    rsp_ok_d      = 1'b1;
                    rsp_slot_d    = slot_q;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        occ_d  = popcount_valid(tab_d);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_host or negedge rst_host) begin
        if (!rst_host) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            gnt_q      <= '0;
            op_q       <= OP_INSTALL;
            slot_q     <= '0;
            off_q      <= '0;
            match_q    <= '0;
            buf_q      <= '0;
            tab_q      <= '0;
            occ_q      <= '0;
            busy_q     <= 1'b0;
            rsp_vld_q  <= '0;
            rsp_ok_q   <= 1'b0;
            rsp_slot_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            op_q       <= op_d;
            slot_q     <= slot_d;
            off_q      <= off_d;
            match_q    <= match_d;
            buf_q      <= buf_d;
            tab_q      <= tab_d;
            occ_q      <= occ_d;
            busy_q     <= busy_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_ok_q   <= rsp_ok_d;
            rsp_slot_q <= rsp_slot_d;
        end
    end

endmodule
